// File: rtl/keccak_perm_arbiter_if.sv
// Client/core handshake bundle for the Keccak-p[400] permutation arbiter.
// The slave side is the arbiter; the master side is everything around it
// (the two requesting clients plus the shared permutation core).
interface keccak_perm_arbiter_if #(
   parameter int STATE_W  = 400,
   parameter int ROUNDS_W = 5
) ();
   logic                i_req_a;
   logic                i_req_b;
   logic [ROUNDS_W-1:0] i_v_rounds_a;
   logic [ROUNDS_W-1:0] i_v_rounds_b;
   logic [STATE_W-1:0]  i_v_state_a;
   logic [STATE_W-1:0]  i_v_state_b;
   logic                o_ack_a;
   logic                o_ack_b;
   logic                o_done_a;
   logic                o_done_b;
   logic                o_err_a;
   logic                o_err_b;
   logic [STATE_W-1:0]  o_v_result;
   logic                o_start;
   logic [ROUNDS_W-1:0] o_v_numberOfRounds;
   logic [STATE_W-1:0]  o_v_perm_state;
   logic                i_perm_done;
   logic [STATE_W-1:0]  i_v_perm_state;
   logic                o_busy;
   logic                o_owner;

   modport slave (
      input  i_req_a, i_req_b, i_v_rounds_a, i_v_rounds_b, i_v_state_a, i_v_state_b,
      input  i_perm_done, i_v_perm_state,
      output o_ack_a, o_ack_b, o_done_a, o_done_b, o_err_a, o_err_b, o_v_result,
      output o_start, o_v_numberOfRounds, o_v_perm_state, o_busy, o_owner
   );

   modport master (
      output i_req_a, i_req_b, i_v_rounds_a, i_v_rounds_b, i_v_state_a, i_v_state_b,
      output i_perm_done, i_v_perm_state,
      input  o_ack_a, o_ack_b, o_done_a, o_done_b, o_err_a, o_err_b, o_v_result,
      input  o_start, o_v_numberOfRounds, o_v_perm_state, o_busy, o_owner
   );
endinterface

// File: rtl/keccak_perm_arbiter.sv
// Round-robin scheduler that shares one Keccak-p[400] permutation core between
// two clients. A grant latches the client's state and round count, the core is
// started and watched by a watchdog, and the permuted state is handed back with
// a done pulse (or an err pulse for an illegal round count or a hung core).
// Every output is a register, so all pulses appear one cycle after the decision.
module keccak_perm_arbiter #(
   parameter int STATE_W    = 400,
   parameter int ROUNDS_W   = 5,
   parameter int MAX_ROUNDS = 20,
   parameter int TIMEOUT    = 63
) (
   input logic                  i_clk,
   input logic                  i_rst,
   keccak_perm_arbiter_if.slave bus
);
   localparam int WD_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, START, BUSY, RESP, ERR} state_t;

   state_t              state;
   state_t              state_n;
   logic [WD_W-1:0]     watchdog;
   logic                last_grant;
   logic                grant;
   logic                grant_b;
   logic                owner_n;
   logic                capture;
   logic [ROUNDS_W-1:0] sel_rounds;
   logic [STATE_W-1:0]  sel_state;

   // Next-state decision: arbitration in IDLE, core supervision in START/BUSY
   always_comb begin
      state_n    = state;
      grant      = 1'b0;
      grant_b    = 1'b0;
      capture    = 1'b0;
      owner_n    = bus.o_owner;
      sel_rounds = bus.i_v_rounds_a;
      sel_state  = bus.i_v_state_a;
      case (state)
         IDLE: begin
            if (bus.i_req_a || bus.i_req_b) begin
               grant   = 1'b1;
               grant_b = (bus.i_req_a && bus.i_req_b) ? ~last_grant : bus.i_req_b;
               owner_n = grant_b;
               if (grant_b) begin
                  sel_rounds = bus.i_v_rounds_b;
                  sel_state  = bus.i_v_state_b;
               end
               if ((sel_rounds == '0) || (sel_rounds > ROUNDS_W'(MAX_ROUNDS))) begin
                  state_n = ERR;
               end else begin
                  state_n = START;
               end
            end
         end
         START: begin
            capture = bus.i_perm_done;
            state_n = bus.i_perm_done ? RESP : BUSY;
         end
         BUSY: begin
            if (bus.i_perm_done) begin
               capture = 1'b1;
               state_n = RESP;
            end else if (watchdog == WD_W'(TIMEOUT)) begin
               state_n = ERR;
            end
         end
         RESP:    state_n = IDLE;
         ERR:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // FSM state register; reset abandons any job in flight without a response
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Watchdog counts BUSY cycles only and is cleared everywhere else
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         watchdog <= '0;
      end else if (state == BUSY) begin
         watchdog <= watchdog + WD_W'(1);
      end else begin
         watchdog <= '0;
      end
   end

   // Registered Moore outputs derived from the state being entered
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         bus.o_ack_a  <= 1'b0;
         bus.o_ack_b  <= 1'b0;
         bus.o_start  <= 1'b0;
         bus.o_busy   <= 1'b0;
         bus.o_done_a <= 1'b0;
         bus.o_done_b <= 1'b0;
         bus.o_err_a  <= 1'b0;
         bus.o_err_b  <= 1'b0;
         bus.o_owner  <= 1'b0;
      end else begin
         bus.o_ack_a  <= grant && !grant_b;
         bus.o_ack_b  <= grant && grant_b;
         bus.o_start  <= (state_n == START);
         bus.o_busy   <= (state_n != IDLE);
         bus.o_done_a <= (state_n == RESP) && !owner_n;
         bus.o_done_b <= (state_n == RESP) && owner_n;
         bus.o_err_a  <= (state_n == ERR) && !owner_n;
         bus.o_err_b  <= (state_n == ERR) && owner_n;
         bus.o_owner  <= owner_n;
      end
   end

   // Grant-time latches for the core inputs; last_grant starts at B so A wins the first tie
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         last_grant             <= 1'b1;
         bus.o_v_perm_state     <= '0;
         bus.o_v_numberOfRounds <= '0;
      end else if (grant) begin
         last_grant             <= grant_b;
         bus.o_v_perm_state     <= sel_state;
         bus.o_v_numberOfRounds <= sel_rounds;
      end
   end

   // Result capture only while a job is running, so a late core done is ignored
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         bus.o_v_result <= '0;
      end else if (capture) begin
         bus.o_v_result <= bus.i_v_perm_state;
      end
   end
endmodule

// File: tb/tb_keccak_perm_arbiter.sv
// Testbench for keccak_perm_arbiter: a vector table of jobs run through a
// behavioural core model, with every done/err response checked against a
// scoreboard queue, plus hand-written single-job, timeout and reset sequences.
module tb_keccak_perm_arbiter;
   localparam int STATE_W    = 400;
   localparam int ROUNDS_W   = 5;
   localparam int MAX_ROUNDS = 20;
   localparam int TIMEOUT    = 63;
   localparam logic [STATE_W-1:0] XOR_MASK = STATE_W'(8'hFF);

   typedef struct {
      logic                req_a;
      logic                req_b;
      logic [ROUNDS_W-1:0] rounds_a;
      logic [ROUNDS_W-1:0] rounds_b;
      logic [31:0]         seed_a;
      logic [31:0]         seed_b;
      int                  delay;
      logic [4:0]          exp_cycle1;
      logic                exp_first_b;
      logic                exp_err1;
      logic                exp_err2;
      int                  exp_starts;
   } vec_t;

   typedef struct {
      logic [3:0]         code;
      logic [STATE_W-1:0] result;
   } exp_t;

   logic i_clk;
   logic i_rst;

   int                 checks;
   int                 passes;
   int                 start_count;
   int                 core_delay;
   int                 core_cnt;
   logic               late_done;
   logic [STATE_W-1:0] core_input;
   logic [STATE_W-1:0] last_result;
   exp_t               sb_q[$];
   exp_t               mon_exp;
   logic [3:0]         mon_code;
   vec_t               vecs[8];
   vec_t               rst_vec;

   keccak_perm_arbiter_if #(.STATE_W(STATE_W), .ROUNDS_W(ROUNDS_W)) bus ();

   keccak_perm_arbiter #(
      .STATE_W   (STATE_W),
      .ROUNDS_W  (ROUNDS_W),
      .MAX_ROUNDS(MAX_ROUNDS),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .bus  (bus)
   );

   // Free-running clock
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // Hard stop in case the DUT wedges somewhere a bounded wait does not cover
   initial begin
      #500000;
      $display("[TB] FAIL global_timeout: simulation still running, expected to have finished");
      $fatal(1, "[TB] global timeout");
   end

   function automatic logic [STATE_W-1:0] makeState(input logic [31:0] seed);
      return STATE_W'({13{seed}});
   endfunction

   task automatic checkOutput(input string name, input logic [STATE_W-1:0] actual,
                              input logic [STATE_W-1:0] expected);
      checks++;
      if (actual === expected) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Push one expected response; order of pushes is the order jobs complete
   task automatic pushJob(input logic is_b, input logic is_err, input logic [STATE_W-1:0] st);
      exp_t e;
      if (is_err) begin
         e.code   = is_b ? 4'b0001 : 4'b0010;
         e.result = last_result;
      end else begin
         e.code      = is_b ? 4'b0100 : 4'b1000;
         e.result    = st ^ XOR_MASK;
         last_result = e.result;
      end
      sb_q.push_back(e);
   endtask

   // Core model: done core_delay cycles after start with state XOR 0xFF; 0 means never
   initial begin
      bus.i_perm_done    = 1'b0;
      bus.i_v_perm_state = '0;
      core_cnt           = 0;
      core_input         = '0;
      start_count        = 0;
      forever begin
         @(negedge i_clk);
         bus.i_perm_done = 1'b0;
         if (i_rst !== 1'b1) begin
            core_cnt = 0;
         end else begin
            if (core_cnt > 0) begin
               core_cnt--;
               if (core_cnt == 0) begin
                  bus.i_perm_done    = 1'b1;
                  bus.i_v_perm_state = core_input ^ XOR_MASK;
               end
            end
            if (late_done) begin
               bus.i_perm_done    = 1'b1;
               bus.i_v_perm_state = ~core_input;
            end
            if (bus.o_start) begin
               start_count++;
               core_cnt   = core_delay;
               core_input = bus.o_v_perm_state;
            end
         end
      end
   end

   // Response monitor: every done/err pulse must match the head of the scoreboard
   initial begin
      forever begin
         @(negedge i_clk);
         mon_code = {bus.o_done_a, bus.o_done_b, bus.o_err_a, bus.o_err_b};
         if (mon_code != 4'b0000) begin
            if (sb_q.size() == 0) begin
               checkOutput("unexpected_response", STATE_W'(mon_code), '0);
            end else begin
               mon_exp = sb_q.pop_front();
               checkOutput("resp_kind", STATE_W'(mon_code), STATE_W'(mon_exp.code));
               checkOutput("resp_result", bus.o_v_result, mon_exp.result);
            end
         end
      end
   end

   // Run one table entry from an IDLE negedge until the arbiter is idle again
   task automatic applyStimulus(input vec_t v, input int idx);
      int                 starts_before;
      int                 cycles;
      logic [STATE_W-1:0] st_a;
      logic [STATE_W-1:0] st_b;
      st_a          = makeState(v.seed_a);
      st_b          = makeState(v.seed_b);
      starts_before = start_count;
      core_delay    = v.delay;
      bus.i_v_state_a  = st_a;
      bus.i_v_state_b  = st_b;
      bus.i_v_rounds_a = v.rounds_a;
      bus.i_v_rounds_b = v.rounds_b;
      if (v.exp_first_b) pushJob(1'b1, v.exp_err1, st_b);
      else               pushJob(1'b0, v.exp_err1, st_a);
      if (v.req_a && v.req_b) begin
         if (v.exp_first_b) pushJob(1'b0, v.exp_err2, st_a);
         else               pushJob(1'b1, v.exp_err2, st_b);
      end
      bus.i_req_a = v.req_a;
      bus.i_req_b = v.req_b;
      @(negedge i_clk);
      checkOutput($sformatf("vec%0d_cycle1", idx),
                  STATE_W'({bus.o_ack_a, bus.o_ack_b, bus.o_start, bus.o_err_a, bus.o_err_b}),
                  STATE_W'(v.exp_cycle1));
      checkOutput($sformatf("vec%0d_owner", idx), STATE_W'(bus.o_owner), STATE_W'(v.exp_first_b));
      cycles = 0;
      forever begin
         if (bus.o_done_a || bus.o_err_a) bus.i_req_a = 1'b0;
         if (bus.o_done_b || bus.o_err_b) bus.i_req_b = 1'b0;
         if (!bus.i_req_a && !bus.i_req_b && !bus.o_busy) break;
         if (cycles >= 400) begin
            checks++;
            $display("[TB] FAIL vec%0d_wait: no completion after %0d cycles, expected idle", idx, cycles);
            bus.i_req_a = 1'b0;
            bus.i_req_b = 1'b0;
            break;
         end
         @(negedge i_clk);
         cycles++;
      end
      checkOutput($sformatf("vec%0d_starts", idx), STATE_W'(start_count - starts_before),
                  STATE_W'(v.exp_starts));
   endtask

   // Main sequence
   initial begin
      int                 cyc;
      int                 extra;
      logic [STATE_W-1:0] st;
      checks      = 0;
      passes      = 0;
      late_done   = 1'b0;
      core_delay  = 0;
      last_result = '0;
      bus.i_req_a      = 1'b0;
      bus.i_req_b      = 1'b0;
      bus.i_v_rounds_a = '0;
      bus.i_v_rounds_b = '0;
      bus.i_v_state_a  = '0;
      bus.i_v_state_b  = '0;
      i_rst            = 1'b0;

      vecs[0] = '{1'b1, 1'b1, 5'd20, 5'd3,  32'h0BADC0DE, 32'h13579BDF, 4,  5'b10100, 1'b0, 1'b0, 1'b0, 2};
      vecs[1] = '{1'b1, 1'b1, 5'd5,  5'd6,  32'hA5A55A5A, 32'h0F0F0F0F, 7,  5'b10100, 1'b0, 1'b0, 1'b0, 2};
      vecs[2] = '{1'b0, 1'b1, 5'd0,  5'd0,  32'h00000000, 32'h11111111, 5,  5'b01001, 1'b1, 1'b1, 1'b0, 0};
      vecs[3] = '{1'b0, 1'b1, 5'd0,  5'd21, 32'h00000000, 32'h22222222, 5,  5'b01001, 1'b1, 1'b1, 1'b0, 0};
      vecs[4] = '{1'b1, 1'b0, 5'd1,  5'd0,  32'h33333333, 32'h00000000, 1,  5'b10100, 1'b0, 1'b0, 1'b0, 1};
      vecs[5] = '{1'b1, 1'b1, 5'd31, 5'd20, 32'h44444444, 32'h55555555, 3,  5'b01100, 1'b1, 1'b0, 1'b1, 1};
      vecs[6] = '{1'b1, 1'b1, 5'd20, 5'd20, 32'h66666666, 32'h77777777, 2,  5'b01100, 1'b1, 1'b0, 1'b0, 2};
      vecs[7] = '{1'b0, 1'b1, 5'd0,  5'd20, 32'h00000000, 32'h88888888, 30, 5'b01100, 1'b1, 1'b0, 1'b0, 1};
      rst_vec = '{1'b1, 1'b1, 5'd4,  5'd9,  32'h9ABCDEF0, 32'h76543210, 2,  5'b10100, 1'b0, 1'b0, 1'b0, 2};

      // Reset state
      @(negedge i_clk);
      checkOutput("reset_ctrl",
                  STATE_W'({bus.o_ack_a, bus.o_ack_b, bus.o_done_a, bus.o_done_b, bus.o_err_a,
                            bus.o_err_b, bus.o_start, bus.o_busy, bus.o_owner}), '0);
      checkOutput("reset_result", bus.o_v_result, '0);
      checkOutput("reset_latches", bus.o_v_perm_state | STATE_W'(bus.o_v_numberOfRounds), '0);
      i_rst = 1'b1;
      @(negedge i_clk);

      // Table-driven jobs: ties, illegal rounds, boundary round counts
      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i], i);
      end

      // Single job: rounds=20, done 20 cycles after start, response at cycle 22
      st               = makeState(32'h12345678);
      core_delay       = 20;
      bus.i_v_rounds_a = 5'd20;
      bus.i_v_state_a  = st;
      pushJob(1'b0, 1'b0, st);
      bus.i_req_a = 1'b1;
      @(negedge i_clk);
      cyc = 1;
      checkOutput("single_ack_start", STATE_W'({bus.o_ack_a, bus.o_start}), STATE_W'(2'b11));
      checkOutput("single_rounds_latched", STATE_W'(bus.o_v_numberOfRounds), STATE_W'(5'd20));
      while (!bus.o_done_a && cyc < 200) begin
         @(negedge i_clk);
         cyc++;
      end
      checkOutput("single_done_cycle", STATE_W'(cyc), STATE_W'(22));
      checkOutput("single_result", bus.o_v_result, st ^ XOR_MASK);
      checkOutput("single_owner", STATE_W'(bus.o_owner), '0);
      bus.i_req_a = 1'b0;
      @(negedge i_clk);

      // Timeout: core never answers; err arrives TIMEOUT+2 cycles after start
      core_delay       = 0;
      bus.i_v_rounds_a = 5'd8;
      bus.i_v_state_a  = makeState(32'hFEEDFACE);
      pushJob(1'b0, 1'b1, '0);
      bus.i_req_a = 1'b1;
      @(negedge i_clk);
      cyc = 1;
      checkOutput("timeout_start", STATE_W'(bus.o_start), STATE_W'(1'b1));
      while (!bus.o_err_a && cyc < 300) begin
         @(negedge i_clk);
         cyc++;
      end
      checkOutput("timeout_err_delay", STATE_W'(cyc - 1), STATE_W'(TIMEOUT + 2));
      bus.i_req_a = 1'b0;
      late_done   = 1'b1;
      extra       = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge i_clk);
         if (i == 1) late_done = 1'b0;
         if (bus.o_done_a || bus.o_done_b || bus.o_busy) extra++;
      end
      checkOutput("late_done_ignored", STATE_W'(extra), '0);
      checkOutput("late_done_result", bus.o_v_result, last_result);

      // Reset in the middle of BUSY: outputs clear at once, next tie goes to A
      core_delay       = 0;
      bus.i_v_rounds_a = 5'd10;
      bus.i_v_state_a  = makeState(32'hCAFEF00D);
      bus.i_req_a      = 1'b1;
      repeat (6) @(negedge i_clk);
      checkOutput("busy_before_reset", STATE_W'(bus.o_busy), STATE_W'(1'b1));
      #2;
      i_rst = 1'b0;
      #1;
      checkOutput("async_reset_ctrl",
                  STATE_W'({bus.o_ack_a, bus.o_ack_b, bus.o_done_a, bus.o_done_b, bus.o_err_a,
                            bus.o_err_b, bus.o_start, bus.o_busy, bus.o_owner}), '0);
      checkOutput("async_reset_result", bus.o_v_result, '0);
      checkOutput("async_reset_latches", bus.o_v_perm_state | STATE_W'(bus.o_v_numberOfRounds), '0);
      bus.i_req_a = 1'b0;
      sb_q.delete();
      last_result = '0;
      @(negedge i_clk);
      i_rst = 1'b1;
      @(negedge i_clk);
      applyStimulus(rst_vec, 8);

      repeat (3) @(negedge i_clk);
      checkOutput("scoreboard_drained", STATE_W'(sb_q.size()), '0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
